packet_reassembly_controller: RTL
=================================

PACKET_REASSEMBLY_CONTROLLER -- requirements
Module: packet_reassembly_controller

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of reassembly slots (>=2).
REQ-002 SHALL have parameter MAX_NUM_OF_FLIT, default packet_types::MAX_NUM_OF_FLIT (8), flit capacity per slot.
REQ-003 SHALL have parameter EXPIRE_TIME, default packet_types::EXPIRE_TIME (100), idle cycles before an incomplete packet is dropped.
REQ-004 SHALL have ports: clk  in  1  clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have rst  in  1  synchronous active-high reset.
REQ-006 SHALL have in_valid in 1, in_ready out 1, in_flit in $bits(types::flit_t), in_packet_id in $bits(types::packet_id_t), in_is_tail in 1: incoming flit stream.
REQ-007 SHALL have out_valid out 1, out_ready in 1, out_flit out $bits(types::flit_t), out_packet_id out $bits(types::packet_id_t), out_last out 1: reassembled packet stream.
REQ-008 SHALL have drop_valid out 1 (one-cycle pulse) and drop_packet_id out $bits(types::packet_id_t): discarded-packet report.
REQ-009 SHALL have busy_slots out $clog2(NUM_SLOTS+1): count of non-FREE slots.

Function
REQ-010 Each slot SHALL be in one of FREE, FILL, COMPLETE, DRAIN; slot data held as packet_types::packet_element_t.
REQ-011 Flit accepted on in_valid && in_ready; in_ready SHALL be combinational: 1 if a FILL slot matches in_packet_id, else 1 if any slot is FREE, else 0.
REQ-012 Match: flit written at buffer[tail_index+1], tail_index incremented, timer cleared.
REQ-013 No match: lowest-index FREE slot allocated, packet_id stored, flit at buffer[0], tail_index=0, timer=0, state FILL.
REQ-014 Accepted flit with in_is_tail=1 SHALL move the slot to COMPLETE (is_complete=1) next cycle, including a single-flit packet.
REQ-015 Overflow: non-tail flit accepted while tail_index==MAX_NUM_OF_FLIT-1 -> slot SHALL go FILL->FREE, flit discarded, drop reported; a tail flit at that point still completes normally.
REQ-016 FILL slot timer SHALL increment each cycle without an accepted flit; at EXPIRE_TIME-1 it saturates and slot is expired.
REQ-017 Expired slots SHALL be freed and reported (drop_valid=1, drop_packet_id) one per cycle, lowest index first; others hold until reported.
REQ-018 Arrival on an expired-but-unreported slot SHALL revive it (timer cleared, no drop); arrival beats expiry in the same cycle.
REQ-019 Timers SHALL NOT run in COMPLETE or DRAIN.
REQ-020 When no slot is in DRAIN, a round-robin grant (start after last granted index) SHALL move one COMPLETE slot to DRAIN.
REQ-021 out_valid SHALL assert the cycle after grant; flits index 0..tail_index emitted in order, out_last=1 on index tail_index.
REQ-022 out_flit/out_packet_id/out_last SHALL be stable while out_valid && !out_ready.
REQ-023 Handshake with out_last=1 SHALL free the slot next cycle; next grant earliest that cycle (min one idle cycle between packets).
REQ-024 Latency: tail accepted cycle N -> COMPLETE N+1 -> grant N+1 -> first out_valid N+2 (no competing drain).
REQ-025 A slot freed in cycle N SHALL be allocatable in cycle N+1, not N.
REQ-026 busy_slots SHALL reflect registered slot states.

Reset
REQ-027 On rst: all slots FREE, timers/tail_index 0, out_valid=0, out_last=0, drop_valid=0, busy_slots=0, RR pointer 0.
REQ-028 Reset mid-fill or mid-drain SHALL abandon contents silently (no drop report), in_ready=1 the cycle after rst deasserts.

Structure
REQ-029 slot_state_t enum SHALL be added to package packet_types; packet_element_t reused unchanged.
REQ-030 Round-robin grant SHALL be sub-module rr_arbiter #(N) (req vector, advance, one-hot grant).

Verification
REQ-031 Single packet id=5, 3 flits A,B,C (C tail), out_ready=1 -> out A,B,C id=5, out_last on C, first out_valid 2 cycles after C accepted.
REQ-032 Interleaved ids 1,2 flits alternating, 2 flits each -> two slots used, busy_slots=2, each packet emitted contiguous and in-order.
REQ-033 Id 7 one flit then idle 100 cycles -> drop_valid pulse, drop_packet_id=7, busy_slots returns 0.
REQ-034 4 FILL slots, 5th new id -> in_ready=0 until a slot frees; existing ids still accepted.
REQ-035 9 non-tail flits id=3 -> ninth triggers drop id=3, slot FREE, nothing emitted.
REQ-036 Two COMPLETE slots with out_ready toggling 1010 -> data stable while stalled, RR alternates grants, rst mid-drain clears out_valid next cycle.

Source files
------------

// File: rtl/packet_reassembly_controller_pkg.sv
// packet_reassembly_controller_pkg: shared flit, packet and slot types for the reassembly controller
package packet_types;
  localparam int MAX_NUM_OF_FLIT = 8;
  localparam int EXPIRE_TIME     = 100;
  localparam int FLIT_W          = 32;
  localparam int ID_W            = 8;
  localparam int IDX_W           = $clog2(MAX_NUM_OF_FLIT);
  localparam int TIMER_W         = $clog2(EXPIRE_TIME);
  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [ID_W-1:0] packet_id_t;
  typedef struct packed {
    packet_id_t                        packet_id;
    flit_t [MAX_NUM_OF_FLIT-1:0]       buffer;
    logic [IDX_W-1:0]                  tail_index;
    logic [TIMER_W-1:0]                timer;
    logic                              is_complete;
  } packet_element_t;
  typedef enum logic [1:0] {FREE, FILL, COMPLETE, DRAIN} slot_state_t;
endpackage

// File: rtl/packet_reassembly_controller_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, search starts after the last granted requester
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int W = $clog2(N);
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_idx;
  logic         w_found;
  always_comb begin
    grant   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req[(int'(r_ptr) + k) % N]) begin
        w_found = 1'b1;
        w_idx   = W'((int'(r_ptr) + k) % N);
      end
    end
    grant[w_idx] = w_found;
  end
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (advance && w_found) r_ptr <= (w_idx == W'(N - 1)) ? '0 : w_idx + W'(1);
  end
endmodule

// File: rtl/packet_reassembly_controller.sv
// packet_reassembly_controller: collects interleaved flits per packet id into slots and
// replays each completed packet contiguously, dropping overflowing or stale packets.
module packet_reassembly_controller
  import packet_types::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int MAX_NUM_OF_FLIT = packet_types::MAX_NUM_OF_FLIT,
  parameter int EXPIRE_TIME     = packet_types::EXPIRE_TIME
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  flit_t                          in_flit,
  input  packet_id_t                     in_packet_id,
  input  logic                           in_is_tail,
  output logic                           out_valid,
  input  logic                           out_ready,
  output flit_t                          out_flit,
  output packet_id_t                     out_packet_id,
  output logic                           out_last,
  output logic                           drop_valid,
  output packet_id_t                     drop_packet_id,
  output logic [$clog2(NUM_SLOTS+1)-1:0] busy_slots
);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int BW = $clog2(NUM_SLOTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_NUM_OF_FLIT - 1);
  localparam logic [TIMER_W-1:0] TMAX = TIMER_W'(EXPIRE_TIME - 1);
  slot_state_t          r_st [NUM_SLOTS];
  packet_element_t      r_el [NUM_SLOTS];
  logic [SW-1:0]        r_drain;
  logic [IDX_W-1:0]     r_rd;
  logic                 r_drop_valid;
  packet_id_t           r_drop_id;
  logic [NUM_SLOTS-1:0] w_match, w_free, w_exp, w_cmpl, w_gnt;
  logic [SW-1:0]        w_hit, w_alloc, w_exp_idx, w_gnt_idx;
  logic                 w_draining, w_acc, w_ovf, w_exp_fire, w_adv, w_hs;
  // An arriving flit for a slot shields it from expiry this cycle.
  always_comb begin
    w_match    = '0;
    w_free     = '0;
    w_exp      = '0;
    w_cmpl     = '0;
    w_draining = 1'b0;
    w_hit      = '0;
    w_alloc    = '0;
    w_exp_idx  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      w_match[i] = r_st[i] == FILL && r_el[i].packet_id == in_packet_id;
      w_free[i]  = r_st[i] == FREE;
      w_exp[i]   = r_st[i] == FILL && r_el[i].timer == TMAX && !(in_valid && w_match[i]);
      w_cmpl[i]  = r_st[i] == COMPLETE;
      w_draining = w_draining || r_st[i] == DRAIN;
      w_hit      = w_match[i] ? SW'(i) : w_hit;
      w_alloc    = w_free[i] ? SW'(i) : w_alloc;
      w_exp_idx  = w_exp[i] ? SW'(i) : w_exp_idx;
    end
  end
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) w_gnt_idx = w_gnt[i] ? SW'(i) : w_gnt_idx;
  end
  always_comb begin
    busy_slots = '0;
    for (int i = 0; i < NUM_SLOTS; i++) busy_slots = busy_slots + BW'(r_st[i] != FREE);
  end
  assign in_ready       = |w_match || |w_free;
  assign w_acc          = in_valid && in_ready;
  assign w_ovf          = w_acc && |w_match && !in_is_tail && r_el[w_hit].tail_index == LAST_IDX;
  assign w_exp_fire     = |w_exp && !w_ovf;
  assign w_adv          = !w_draining && |w_cmpl;
  assign w_hs           = out_valid && out_ready;
  assign out_valid      = w_draining;
  assign out_flit       = r_el[r_drain].buffer[r_rd];
  assign out_packet_id  = r_el[r_drain].packet_id;
  assign out_last       = w_draining && r_rd == r_el[r_drain].tail_index;
  assign drop_valid     = r_drop_valid;
  assign drop_packet_id = r_drop_id;
  rr_arbiter #(.N(NUM_SLOTS)) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (w_cmpl),
    .advance(w_adv),
    .grant  (w_gnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_st[i] <= FREE;
        r_el[i] <= '0;
      end
      r_drain      <= '0;
      r_rd         <= '0;
      r_drop_valid <= 1'b0;
      r_drop_id    <= '0;
    end else begin
      r_drop_valid <= w_ovf || w_exp_fire;
      r_drop_id    <= w_ovf ? in_packet_id : r_el[w_exp_idx].packet_id;
      for (int i = 0; i < NUM_SLOTS; i++)
        if (r_st[i] == FILL && r_el[i].timer != TMAX) r_el[i].timer <= r_el[i].timer + 1'b1;
      if (w_exp_fire) r_st[w_exp_idx] <= FREE;
      if (w_acc && |w_match) begin
        r_el[w_hit].timer <= '0;
        if (w_ovf) r_st[w_hit] <= FREE;
        else begin
          if (r_el[w_hit].tail_index != LAST_IDX) begin
            r_el[w_hit].buffer[r_el[w_hit].tail_index + 1'b1] <= in_flit;
            r_el[w_hit].tail_index <= r_el[w_hit].tail_index + 1'b1;
          end
          if (in_is_tail) begin
            r_st[w_hit]             <= COMPLETE;
            r_el[w_hit].is_complete <= 1'b1;
          end
        end
      end else if (w_acc) begin
        r_el[w_alloc].packet_id   <= in_packet_id;
        r_el[w_alloc].buffer[0]   <= in_flit;
        r_el[w_alloc].tail_index  <= '0;
        r_el[w_alloc].timer       <= '0;
        r_el[w_alloc].is_complete <= in_is_tail;
        r_st[w_alloc]             <= in_is_tail ? COMPLETE : FILL;
      end
      if (w_adv) begin
        r_st[w_gnt_idx] <= DRAIN;
        r_drain         <= w_gnt_idx;
        r_rd            <= '0;
      end else if (w_hs && out_last) begin
        r_st[r_drain]             <= FREE;
        r_el[r_drain].is_complete <= 1'b0;
      end else if (w_hs) r_rd <= r_rd + 1'b1;
    end
  end
endmodule
